// File: rtl/leaky_relu_scheduler.sv
// Round-robin scheduler sharing one two-stage 8-bit LeakyReLU pipeline among NUM_REQ requesters.
// Define LRELU_PERF_EN to add saturating perf_out_cnt / perf_stall_cnt outputs.
module leaky_relu_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int SHIFT_RST = 3,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        cfg_we,
  input  logic [2:0]                  cfg_shift,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [ID_W-1:0]             out_id,
  input  logic                        out_ready
`ifdef LRELU_PERF_EN
  ,
  output logic [15:0]                 perf_out_cnt,
  output logic [15:0]                 perf_stall_cnt
`endif
);

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return ID_W'(s);
  endfunction

  // Negative inputs are scaled by 2^-sh with an arithmetic shift (rounds toward -inf).
  function automatic logic [DATA_W-1:0] leaky(input logic [DATA_W-1:0] x, input logic [2:0] sh);
    logic signed [DATA_W-1:0] xs;
    xs = $signed(x);
    if (x[DATA_W-1]) return DATA_W'(xs >>> sh);
    else             return x;
  endfunction

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [2:0]        shift_q, shift_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic [2:0]        s1_shift_q, s1_shift_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [ID_W-1:0]   s2_id_q, s2_id_d;

  logic              s2_stall;
  logic              s1_advance;
  logic              s1_can_load;
  logic              grant_found;
  logic              grant_en;
  logic [ID_W-1:0]   grant_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[rr_index(ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_index(ptr_q, k);
      end
    end
  end

  // S1 may only take a new element if it is empty or its content moves into S2 this cycle.
  always_comb begin
    s2_stall    = s2_valid_q & ~out_ready;
    s1_advance  = s1_valid_q & ~s2_stall;
    s1_can_load = ~s1_valid_q | ~s2_stall;
    grant_en    = grant_found & s1_can_load & ~rst;
    req_ready   = grant_en ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    ptr_d      = ptr_q;
    shift_d    = cfg_we ? cfg_shift : shift_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_id_d    = s1_id_q;
    s1_shift_d = s1_shift_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;

    if (grant_en) begin
      ptr_d      = rr_index(grant_idx, 1);
      s1_valid_d = 1'b1;
      s1_data_d  = req_data[grant_idx*DATA_W +: DATA_W];
      s1_id_d    = grant_idx;
      s1_shift_d = shift_q;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    if (!s2_stall) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = leaky(s1_data_q, s1_shift_q);
        s2_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      shift_q    <= 3'(SHIFT_RST);
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      s1_shift_q <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      shift_q    <= shift_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_id_q    <= s1_id_d;
      s1_shift_q <= s1_shift_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_id    = s2_id_q;

`ifdef LRELU_PERF_EN
  logic [15:0] perf_out_q, perf_out_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_out_d   = perf_out_q;
    perf_stall_d = perf_stall_q;
    if (s2_valid_q && out_ready && (perf_out_q != 16'hFFFF))
      perf_out_d = perf_out_q + 16'd1;
    if (s2_stall && (perf_stall_q != 16'hFFFF))
      perf_stall_d = perf_stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_out_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_out_q   <= perf_out_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_out_cnt   = perf_out_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_leaky_relu_scheduler.sv
// Directed self-checking bench for leaky_relu_scheduler (NUM_REQ=4, DATA_W=8, SHIFT_RST=3).
module tb_leaky_relu_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        cfg_we;
  logic [2:0]  cfg_shift;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ready;
`ifdef LRELU_PERF_EN
  logic [15:0] perf_out_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  leaky_relu_scheduler #(.NUM_REQ(4), .DATA_W(8), .SHIFT_RST(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cfg_we    (cfg_we),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
`ifdef LRELU_PERF_EN
    ,
    .perf_out_cnt   (perf_out_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_data = '0; cfg_we = 1'b0; cfg_shift = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 4'hF; req_data = 32'h5A5A5A5A; cfg_we = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (out_id !== 2'd0) begin failures++; $display("[TB] FAIL reset_out_id got=%0d exp=0", out_id); end
    @(negedge clk);
    rst = 1'b0; req_valid = '0; req_data = '0;
  endtask

  task automatic test_basic();
    logic [7:0] vin [4];
    logic [7:0] vexp [4];
    vin  = '{8'd100, 8'd200, 8'd0, 8'd255};
    vexp = '{8'd100, 8'd249, 8'd0, 8'd255};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = (c < 4) ? 4'b0001 : 4'b0000;
      req_data  = '0;
      if (c < 4) set_data(0, vin[c]);
      #1;
      checks++; if (req_ready[0] !== (c < 4)) begin failures++; $display("[TB] FAIL basic_ready c=%0d got=%b exp=%b", c, req_ready[0], (c < 4)); end
      if (c >= 2 && c <= 5) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid c=%0d got=%b exp=1", c, out_valid); end
        checks++; if (out_data !== vexp[c-2]) begin failures++; $display("[TB] FAIL basic_data c=%0d got=%h exp=%h", c, out_data, vexp[c-2]); end
        checks++; if (out_id !== 2'd0) begin failures++; $display("[TB] FAIL basic_id c=%0d got=%0d exp=0", c, out_id); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle c=%0d got=%b exp=0", c, out_valid); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      req_valid = (c < 8) ? 4'hF : 4'h0;
      for (int i = 0; i < 4; i++) set_data(i, 8'(10 + i));
      #1;
      exp_ready = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_ready) begin failures++; $display("[TB] FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
      if (c >= 2 && c < 10) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rr_valid c=%0d got=%b exp=1", c, out_valid); end
        checks++; if (out_id !== 2'((c - 2) % 4)) begin failures++; $display("[TB] FAIL rr_id c=%0d got=%0d exp=%0d", c, out_id, (c - 2) % 4); end
        checks++; if (out_data !== 8'(10 + (c - 2) % 4)) begin failures++; $display("[TB] FAIL rr_data c=%0d got=%h exp=%h", c, out_data, 8'(10 + (c - 2) % 4)); end
      end else if (c == 10) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rr_drain got=%b exp=0", out_valid); end
      end
    end
  endtask

  task automatic test_sparse();
    logic [3:0] exp_ready [4];
    logic [1:0] exp_id [4];
    logic [7:0] exp_dat [4];
    exp_ready = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    exp_id    = '{2'd1, 2'd3, 2'd1, 2'd3};
    exp_dat   = '{8'hFF, 8'h40, 8'hFF, 8'h40};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = (c < 4) ? 4'b1010 : 4'b0000;
      req_data  = '0;
      set_data(1, 8'hF8);
      set_data(3, 8'h40);
      #1;
      if (c < 4) begin
        checks++; if (req_ready !== exp_ready[c]) begin failures++; $display("[TB] FAIL sparse_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready[c]); end
      end
      if (c >= 2 && c < 6) begin
        checks++; if (out_id !== exp_id[c-2]) begin failures++; $display("[TB] FAIL sparse_id c=%0d got=%0d exp=%0d", c, out_id, exp_id[c-2]); end
        checks++; if (out_data !== exp_dat[c-2]) begin failures++; $display("[TB] FAIL sparse_data c=%0d got=%h exp=%h", c, out_data, exp_dat[c-2]); end
      end
    end
  endtask

  task automatic test_stall();
    int sent;
    int rcv;
    sent = 0;
    rcv  = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 7);
      req_valid = (sent < 8) ? 4'b0100 : 4'b0000;
      req_data  = '0;
      set_data(2, 8'(20 + sent));
      #1;
      if (c >= 3 && c <= 7) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid c=%0d got=%b exp=1", c, out_valid); end
        checks++; if (out_data !== 8'(20 + rcv)) begin failures++; $display("[TB] FAIL stall_hold_data c=%0d got=%h exp=%h", c, out_data, 8'(20 + rcv)); end
        checks++; if (out_id !== 2'd2) begin failures++; $display("[TB] FAIL stall_hold_id c=%0d got=%0d exp=2", c, out_id); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL stall_ready c=%0d got=%b exp=0000", c, req_ready); end
      end
      if (req_ready[2] && req_valid[2]) sent++;
      if (out_valid && out_ready) begin
        checks++; if (out_data !== 8'(20 + rcv)) begin failures++; $display("[TB] FAIL stall_seq_data n=%0d got=%h exp=%h", rcv, out_data, 8'(20 + rcv)); end
        checks++; if (out_id !== 2'd2) begin failures++; $display("[TB] FAIL stall_seq_id n=%0d got=%0d exp=2", rcv, out_id); end
        rcv++;
      end
    end
    checks++; if (sent !== 8) begin failures++; $display("[TB] FAIL stall_sent got=%0d exp=8", sent); end
    checks++; if (rcv !== 8) begin failures++; $display("[TB] FAIL stall_received got=%0d exp=8", rcv); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_drained got=%b exp=0", out_valid); end
`ifdef LRELU_PERF_EN
    checks++; if (perf_out_cnt !== 16'd8) begin failures++; $display("[TB] FAIL perf_out got=%0d exp=8", perf_out_cnt); end
    checks++; if (perf_stall_cnt !== 16'd5) begin failures++; $display("[TB] FAIL perf_stall got=%0d exp=5", perf_stall_cnt); end
`endif
  endtask

  task automatic test_config();
    logic       vv  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] vd  [10] = '{8'hC8, 8'hC8, 8'h00, 8'h80, 8'hFF, 8'h7F, 8'h9C, 8'h00, 8'h00, 8'h00};
    logic       vwe [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] vsh [10] = '{3'd1, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic       ev  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed  [10] = '{8'h00, 8'h00, 8'hF9, 8'hE4, 8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h9C, 8'h00};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = {3'b000, vv[c]};
      req_data  = '0;
      set_data(0, vd[c]);
      cfg_we    = vwe[c];
      cfg_shift = vsh[c];
      #1;
      checks++; if (req_ready[0] !== vv[c]) begin failures++; $display("[TB] FAIL cfg_ready c=%0d got=%b exp=%b", c, req_ready[0], vv[c]); end
      checks++; if (out_valid !== ev[c]) begin failures++; $display("[TB] FAIL cfg_valid c=%0d got=%b exp=%b", c, out_valid, ev[c]); end
      if (ev[c]) begin
        checks++; if (out_data !== ed[c]) begin failures++; $display("[TB] FAIL cfg_data c=%0d got=%h exp=%h", c, out_data, ed[c]); end
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    @(negedge clk);
    cfg_we = 1'b1; cfg_shift = 3'd5; req_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0; req_valid = 4'b0011; req_data = '0; set_data(0, 8'h40); set_data(1, 8'h41);
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL mid_fill0 got=%b exp=0001", req_ready); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL mid_fill1 got=%b exp=0010", req_ready); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL mid_full_ready got=%b exp=0000", req_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h40) begin failures++; $display("[TB] FAIL mid_full_out got=%b/%h exp=1/40", out_valid, out_data); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL mid_rst_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; req_valid = 4'b0110; req_data = '0; set_data(1, 8'hC8); set_data(2, 8'h10);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_post_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00 || out_id !== 2'd0) begin failures++; $display("[TB] FAIL mid_post_out got=%h/%0d exp=00/0", out_data, out_id); end
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL mid_post_ptr got=%b exp=0010", req_ready); end
`ifdef LRELU_PERF_EN
    checks++; if (perf_out_cnt !== 16'd0 || perf_stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL mid_perf_clear got=%0d/%0d exp=0/0", perf_out_cnt, perf_stall_cnt); end
`endif
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_discard got=%b exp=0", out_valid); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hF9 || out_id !== 2'd1) begin failures++; $display("[TB] FAIL mid_shift_rst got=%b/%h/%0d exp=1/f9/1", out_valid, out_data, out_id); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_no_dup got=%b exp=0", out_valid); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; cfg_we = 1'b0; cfg_shift = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_sparse();
    test_stall();
    test_config();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
